ccd_pixel_capture: RTL
======================

Name: ccd_pixel_capture

Overview:
Receive-side companion to the TCD1304 driver. It aligns to the driver's ICG rising edge and counts pixel periods of the CCD output. It samples the external ADC once per pixel, discards leading dummy pixels, and streams the active pixels out over a valid/ready interface with frame markers and status flags. It sits between the ADC input pins and the downstream correlation/processing logic, on the same 50 MHz clock as the driver.

Parameters:
ADC_W, 12, ADC sample width.
CLK_PER_PIX, 200, clk cycles per CCD pixel (4 M periods at M = 1 MHz, clk = 50 MHz).
LEAD_DUMMY, 32, dummy pixels discarded after the ICG rising edge.
ACTIVE_PIX, 3648, active pixels captured per frame.
SAMPLE_OFFSET, 100, phase within a pixel at which adc_data is sampled; must be < CLK_PER_PIX.
IDX_W, 12, pixel index width; must satisfy 2^IDX_W >= ACTIVE_PIX.

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
ICG  in  1  integration clear gate from the driver; asynchronous to the capture phase, so it is synchronized internally
adc_data  in  ADC_W  ADC output, stable around SAMPLE_OFFSET
ovf_clr  in  1  single-cycle pulse that clears overflow and short_frame
pix_ready  in  1  downstream accept
pix_valid  out  1  pixel word available
pix_data  out  ADC_W  pixel value
pix_index  out  IDX_W  active pixel number, 0..ACTIVE_PIX-1
pix_sof  out  1  qualifies the word with index 0
pix_eof  out  1  qualifies the word with index ACTIVE_PIX-1
frame_busy  out  1  high in LEAD or ACTIVE
frame_cnt  out  16  completed frames, wraps 0xFFFF->0
overflow  out  1  sticky: a sample was dropped
short_frame  out  1  sticky: an ICG edge arrived while a frame was in progress

Behaviour:
- Reset: all outputs 0. State = IDLE, all counters 0, sync flops 0.
- ICG sync: 2-flop synchronizer, then a third flop for edge detect. rise = s2 & ~s3. rise asserts 3 clk after the ICG pin rises.
- State machine:
  - IDLE: on rise -> LEAD; phase = 0, pixcnt = 0.
  - LEAD: phase counts 0..CLK_PER_PIX-1 and wraps. pixcnt increments on each wrap. At pixcnt == LEAD_DUMMY-1 with phase at its wrap value -> ACTIVE; pixcnt = 0.
  - ACTIVE: at phase == SAMPLE_OFFSET, capture adc_data with index = pixcnt. pixcnt increments on each phase wrap. After the sample with index ACTIVE_PIX-1 -> DONE.
  - DONE: one cycle; frame_cnt += 1; -> IDLE.
- rise while in LEAD or ACTIVE: set short_frame, restart in LEAD with phase = 0 and pixcnt = 0. frame_cnt does not increment. Any word already in the output register is kept.
- Output register: single entry holding {data, index, sof, eof}.
  - The capture loads it on the cycle after the sample point.
  - pix_valid stays high until the cycle on which pix_valid & pix_ready; it clears on the next edge unless a new capture loads on that same edge.
  - If a capture occurs while pix_valid=1 and pix_ready=0: the new sample is dropped, overflow is set, and the register is unchanged.
  - Capture and accept on the same cycle: the load wins and no overflow is flagged.
- ovf_clr clears both sticky flags. If ovf_clr coincides with a set event, the set wins.
- pix_data, pix_index, pix_sof and pix_eof are held stable while pix_valid=1 and not accepted.
- Capture latency from the ICG pin rising edge to the first pix_valid: 3 + LEAD_DUMMY*CLK_PER_PIX + SAMPLE_OFFSET + 1 clk. With defaults this is 6504.

Optional Feature:
CCD_INVERT_EN
- Defined: pix_data = (2^ADC_W - 1) - adc_sample. This compensates for the TCD1304 output voltage falling with light, so brighter pixels give larger values.
- Undefined: pix_data = the raw adc_sample.
- All other timing, flags and handshake behaviour are identical in both builds.

Test Plan:
1. Defaults, pix_ready=1, adc_data = pixel-index ramp, one ICG pulse -> first pix_valid 6504 clk after ICG rises. pix_sof on index 0. 3648 words, indices 0..3647. pix_eof on 3647. frame_cnt 0->1. overflow=0.
2. CLK_PER_PIX=8, LEAD_DUMMY=2, ACTIVE_PIX=4, SAMPLE_OFFSET=3, adc_data=0x0A5 -> exactly 4 words of 0x0A5. First pix_valid 3+16+3+1=23 clk after ICG rises.
3. Small-parameter setup as in 2, pix_ready=0 for the whole frame -> word 0 held with pix_sof=1. overflow set at the second sample. ovf_clr pulse -> overflow=0.
4. Small-parameter setup as in 2, second ICG rise 20 clk after the first -> short_frame=1, frame restarts in LEAD. First word appears 23 clk after the second rise. frame_cnt increments only once, after the second frame completes.
5. Deassert rst_n mid-ACTIVE with pix_valid=1 -> all outputs 0 immediately. No capture until the next ICG rise.
6. Build with CCD_INVERT_EN, ADC_W=12, adc_data=0x100 -> pix_data=0xEFF. Without the macro -> pix_data=0x100.

Source files
------------

// File: rtl/ccd_pixel_capture.sv
// CCD pixel capture: aligns to the driver's ICG rising edge, samples the ADC once per pixel and
// streams active pixels over valid/ready. Define CCD_INVERT_EN to output full-scale minus sample.
module ccd_pixel_capture #(
  parameter int unsigned ADC_W         = 12,
  parameter int unsigned CLK_PER_PIX   = 200,
  parameter int unsigned LEAD_DUMMY    = 32,
  parameter int unsigned ACTIVE_PIX    = 3648,
  parameter int unsigned SAMPLE_OFFSET = 100,
  parameter int unsigned IDX_W         = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ICG,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             ovf_clr,
  input  logic             pix_ready,
  output logic             pix_valid,
  output logic [ADC_W-1:0] pix_data,
  output logic [IDX_W-1:0] pix_index,
  output logic             pix_sof,
  output logic             pix_eof,
  output logic             frame_busy,
  output logic [15:0]      frame_cnt,
  output logic             overflow,
  output logic             short_frame
);

  localparam int unsigned PH_W    = $clog2(CLK_PER_PIX + 1);
  localparam int unsigned CNT_MAX = (LEAD_DUMMY > ACTIVE_PIX) ? LEAD_DUMMY : ACTIVE_PIX;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {StIdle, StLead, StActive, StDone} state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d, phase_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             icg_s1, icg_s2, icg_s3;
  logic             rise, phase_wrap, capture, load, drop;
  logic [ADC_W-1:0] sample;

  assign rise       = icg_s2 & ~icg_s3;
  assign phase_wrap = (phase_q == PH_W'(CLK_PER_PIX - 1));
  assign phase_next = phase_wrap ? '0 : phase_q + 1'b1;
  assign frame_busy = (state_q == StLead) || (state_q == StActive);

`ifdef CCD_INVERT_EN
  assign sample = ~adc_data;
`else
  assign sample = adc_data;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StLead;
          phase_d = '0;
          cnt_d   = '0;
        end
      end
      StLead: begin
        if (rise) begin
          phase_d = '0;
          cnt_d   = '0;
        end else begin
          phase_d = phase_next;
          if (phase_wrap) begin
            if (cnt_q == CNT_W'(LEAD_DUMMY - 1)) begin
              state_d = StActive;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      StActive: begin
        // A restart edge takes priority over a sample falling on the same cycle.
        if (rise) begin
          state_d = StLead;
          phase_d = '0;
          cnt_d   = '0;
        end else begin
          phase_d = phase_next;
          if (phase_wrap) cnt_d = cnt_q + 1'b1;
          if (phase_q == PH_W'(SAMPLE_OFFSET)) begin
            capture = 1'b1;
            if (cnt_q == CNT_W'(ACTIVE_PIX - 1)) state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign load = capture & (~pix_valid | pix_ready);
  assign drop = capture & pix_valid & ~pix_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icg_s1      <= 1'b0;
      icg_s2      <= 1'b0;
      icg_s3      <= 1'b0;
      state_q     <= StIdle;
      phase_q     <= '0;
      cnt_q       <= '0;
      frame_cnt   <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_index   <= '0;
      pix_sof     <= 1'b0;
      pix_eof     <= 1'b0;
      overflow    <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      icg_s1  <= ICG;
      icg_s2  <= icg_s1;
      icg_s3  <= icg_s2;
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      if (state_q == StDone) frame_cnt <= frame_cnt + 16'd1;

      if (load) begin
        pix_valid <= 1'b1;
        pix_data  <= sample;
        pix_index <= IDX_W'(cnt_q);
        pix_sof   <= (cnt_q == '0);
        pix_eof   <= (cnt_q == CNT_W'(ACTIVE_PIX - 1));
      end else if (pix_valid && pix_ready) begin
        pix_valid <= 1'b0;
      end

      // Set events win over a coincident clear.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

      if (rise && frame_busy) short_frame <= 1'b1;
      else if (ovf_clr)       short_frame <= 1'b0;
    end
  end

endmodule
